gyro_fir_filter: RTL and testbench



---
 rtl/gyro_fir_filter_pkg.sv | 44 ++++
 rtl/gyro_fir_filter_mac.sv | 31 +++
 rtl/gyro_fir_filter.sv | 167 ++++++++++++++++
 tb/tb_gyro_fir_filter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gyro_fir_filter_pkg.sv
// Shared defaults, state encoding and output rounding for gyro_fir_filter.
// Build option GYRO_FIR_SAT_EN: saturate the rounded result instead of wrapping it.
package gyro_filt_pkg;

    localparam int DEF_DATA_W   = 10;
    localparam int DEF_COEF_W   = 16;
    localparam int DEF_TAPS     = 10;
    localparam int DEF_CHANNELS = 3;

    // Antisymmetric high-pass set; the taps sum to zero so DC is rejected.
    localparam logic signed [15:0] DEF_COEFS [DEF_TAPS] = '{
        16'hfda5, 16'h0e32, 16'hd54b, 16'h52ed, 16'h8e58,
        16'h71a8, 16'had13, 16'h2ab5, 16'hf1ce, 16'h025b
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MAC,
        ST_OUT
    } filt_state_t;

    // Round half toward +inf, then clamp or wrap into data_w signed bits.
    function automatic longint round_reduce(input longint acc, input int coef_w, input int data_w);
        longint y;
        longint lim;
        y   = (acc + (longint'(1) <<< (coef_w - 2))) >>> (coef_w - 1);
        lim = longint'(1) <<< (data_w - 1);
`ifdef GYRO_FIR_SAT_EN
        if (y > lim - 1) begin
            y = lim - 1;
        end else if (y < -lim) begin
            y = -lim;
        end
`else
        y = (y <<< (64 - data_w)) >>> (64 - data_w);
        if (lim == 0) begin
            y = 0;
        end
`endif
        return y;
    endfunction

endpackage

// File: rtl/gyro_fir_filter_mac.sv
// Shared signed multiply-accumulate for the gyro FIR; clear restarts the sum
// with the current product so no idle cycle is spent between channels.
module fir_mac #(
    parameter int A_W   = 10,
    parameter int B_W   = 16,
    parameter int ACC_W = 30
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    output logic signed [ACC_W-1:0] o_acc_next
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_prod;

    assign w_prod     = ACC_W'(i_a) * ACC_W'(i_b);
    assign o_acc_next = (i_clr ? '0 : r_acc) + w_prod;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/gyro_fir_filter.sv
// Time-multiplexed multi-channel gyro FIR: one shared MAC walks channel-outer, tap-inner.
// Build option GYRO_FIR_SAT_EN (see gyro_filt_pkg) selects saturating output.
module gyro_fir_filter
    import gyro_filt_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int TAPS     = DEF_TAPS,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       SampleValid,
    input  logic [CHANNELS*DATA_W-1:0] GyroIn,
    output logic                       Busy,
    output logic [CHANNELS*DATA_W-1:0] GyroOut,
    output logic                       DataReady,
    input  logic                       CoefWe,
    input  logic [$clog2(TAPS)-1:0]    CoefAddr,
    input  logic [COEF_W-1:0]          CoefData,
    output logic [7:0]                 DropCount
);

    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    filt_state_t r_state;
    filt_state_t w_state_nxt;

    logic signed [DATA_W-1:0] r_dline  [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] r_sample [CHANNELS];
    logic signed [DATA_W-1:0] r_stage  [CHANNELS];
    logic signed [COEF_W-1:0] r_coef   [TAPS];

    logic [TAP_W-1:0]            r_tap;
    logic [CH_W-1:0]             r_ch;
    logic [CHANNELS*DATA_W-1:0]  r_gyro_out;
    logic                        r_ready;
    logic [7:0]                  r_drop;

    logic                        w_busy;
    logic                        w_mac_en;
    logic                        w_mac_clr;
    logic                        w_last_tap;
    logic                        w_last_ch;
    logic signed [ACC_W-1:0]     w_acc_next;

    assign w_last_tap = (r_tap == TAP_W'(TAPS - 1));
    assign w_last_ch  = (r_ch == CH_W'(CHANNELS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_mac_en    = 1'b0;
        w_mac_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (SampleValid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                w_mac_en  = 1'b1;
                w_mac_clr = (r_tap == '0);
                if (w_last_tap && w_last_ch) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fir_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_clk      (Clock),
        .i_rst      (Reset),
        .i_clr      (w_mac_clr),
        .i_en       (w_mac_en),
        .i_a        (r_dline[r_ch][r_tap]),
        .i_b        (r_coef[r_tap]),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_tap      <= '0;
            r_ch       <= '0;
            r_gyro_out <= '0;
            r_ready    <= 1'b0;
            r_drop     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_sample[c] <= '0;
                r_stage[c]  <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    r_dline[c][k] <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= (k < DEF_TAPS) ? COEF_W'(DEF_COEFS[k % DEF_TAPS]) : '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (r_state == ST_OUT);

            // The sample is latched on acceptance so GyroIn may change before SHIFT.
            if (r_state == ST_IDLE) begin
                if (SampleValid) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        r_sample[c] <= GyroIn[c*DATA_W +: DATA_W];
                    end
                end
                if (CoefWe && (int'(CoefAddr) < TAPS)) begin
                    r_coef[CoefAddr] <= CoefData;
                end
            end else if (SampleValid && (r_drop != 8'hff)) begin
                r_drop <= r_drop + 8'd1;
            end

            if (r_state == ST_SHIFT) begin
                r_tap <= '0;
                r_ch  <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        r_dline[c][k] <= r_dline[c][k-1];
                    end
                    r_dline[c][0] <= r_sample[c];
                end
            end

            if (r_state == ST_MAC) begin
                if (w_last_tap) begin
                    r_tap <= '0;
                    r_ch  <= r_ch + CH_W'(1);
                    r_stage[r_ch] <= DATA_W'(round_reduce(longint'(w_acc_next), COEF_W, DATA_W));
                end else begin
                    r_tap <= r_tap + TAP_W'(1);
                end
            end

            if (r_state == ST_OUT) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_gyro_out[c*DATA_W +: DATA_W] <= r_stage[c];
                end
            end
        end
    end

    assign Busy      = w_busy;
    assign GyroOut   = r_gyro_out;
    assign DataReady = r_ready;
    assign DropCount = r_drop;

endmodule

// File: tb/tb_gyro_fir_filter.sv
// Self-checking bench for gyro_fir_filter against a plain-arithmetic FIR reference.
module tb_gyro_fir_filter;

    localparam int DW   = 10;
    localparam int CW   = 16;
    localparam int TAPS = 10;
    localparam int CH   = 3;
    localparam int AW   = 4;

    logic               Clock = 1'b0;
    logic               Reset = 1'b1;
    logic               SampleValid = 1'b0;
    logic [CH*DW-1:0]   GyroIn = '0;
    logic               Busy;
    logic [CH*DW-1:0]   GyroOut;
    logic               DataReady;
    logic               CoefWe = 1'b0;
    logic [AW-1:0]      CoefAddr = '0;
    logic [CW-1:0]      CoefData = '0;
    logic [7:0]         DropCount;

    gyro_fir_filter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SampleValid (SampleValid),
        .GyroIn      (GyroIn),
        .Busy        (Busy),
        .GyroOut     (GyroOut),
        .DataReady   (DataReady),
        .CoefWe      (CoefWe),
        .CoefAddr    (CoefAddr),
        .CoefData    (CoefData),
        .DropCount   (DropCount)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    int m_coef [TAPS];
    int m_hist [CH][TAPS];
    int exp_out [CH];
    int exp_drop;

    localparam int DEF_C [TAPS] = '{-603, 3634, -10933, 21229, -29096,
                                    29096, -21229, 10933, -3634, 603};

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_ch(input int c);
        logic signed [DW-1:0] v;
        v = GyroOut[c*DW +: DW];
        return int'(v);
    endfunction

    function automatic int to_s16(input int d);
        return (d >= 32768) ? d - 65536 : d;
    endfunction

    // Direct convolution, floor((acc + 2^14) / 2^15), then clamp or wrap to 10 bits.
    function automatic int model_y(input int c);
        longint acc = 0;
        longint r;
        for (int k = 0; k < TAPS; k++) acc += longint'(m_coef[k]) * longint'(m_hist[c][k]);
        r = (acc + 16384) >>> 15;
`ifdef GYRO_FIR_SAT_EN
        if (r > 511) r = 511;
        if (r < -512) r = -512;
`else
        r = ((r % 1024) + 1024) % 1024;
        if (r >= 512) r -= 1024;
`endif
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) m_coef[k] = DEF_C[k];
        for (int c = 0; c < CH; c++) begin
            exp_out[c] = 0;
            for (int k = 0; k < TAPS; k++) m_hist[c][k] = 0;
        end
        exp_drop = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic coef_write(input int addr, input int data);
        CoefWe = 1'b1;
        CoefAddr = AW'(addr);
        CoefData = CW'(data);
        @(posedge Clock);
        #1;
        CoefWe = 1'b0;
        if (addr < TAPS) m_coef[addr] = to_s16(data);
    endtask

    // One accepted sample, optional same-cycle coef write, optional poke/reset mid-run.
    task automatic run_probe(input int v0, input int v1, input int v2,
                             input bit we0, input int addr0, input int data0,
                             input int poke_cyc, input bit poke_sv, input bit poke_we,
                             input int rst_cyc);
        int vals [CH];
        int n_ready = 0;
        int lat = -1;
        int waited = 0;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        while (Busy && waited < 100) begin
            @(posedge Clock); #1; waited++;
        end
        check_val("idle_before_sample", Busy, 0);
        GyroIn = {DW'(v2), DW'(v1), DW'(v0)};
        SampleValid = 1'b1;
        CoefWe = we0;
        CoefAddr = AW'(addr0);
        CoefData = CW'(data0);
        @(posedge Clock);
        #1;
        SampleValid = 1'b0;
        CoefWe = 1'b0;
        if (we0 && addr0 < TAPS) m_coef[addr0] = to_s16(data0);
        for (int c = 0; c < CH; c++) begin
            for (int k = TAPS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = vals[c];
        end
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (cyc == poke_cyc) begin
                SampleValid = poke_sv;
                CoefWe = poke_we;
                CoefAddr = '0;
                CoefData = '0;
                GyroIn = '1;
                if (poke_sv && exp_drop < 255) exp_drop++;
            end
            if (cyc == rst_cyc) Reset = 1'b1;
            @(posedge Clock);
            #1;
            SampleValid = 1'b0;
            CoefWe = 1'b0;
            Reset = 1'b0;
            if (DataReady) begin
                n_ready++;
                if (lat < 0) lat = cyc;
            end
            if (cyc == 10 && (rst_cyc <= 0 || rst_cyc > 10)) check_val("busy_mid_compute", Busy, 1);
        end
        if (rst_cyc > 0) begin
            model_reset();
            check_val("ready_after_abort", n_ready, 0);
        end else begin
            check_val("ready_pulse_count", n_ready, 1);
            check_val("latency", lat, 32);
            for (int c = 0; c < CH; c++) exp_out[c] = model_y(c);
        end
        for (int c = 0; c < CH; c++) check_val($sformatf("gyro_out_ch%0d", c), out_ch(c), exp_out[c]);
        check_val("drop_count", DropCount, exp_drop);
    endtask

    task automatic run_sample(input int v0, input int v1, input int v2);
        run_probe(v0, v1, v2, 1'b0, 0, 0, -1, 1'b0, 1'b0, -1);
    endtask

    initial begin
        int a, b, c, sv;
        model_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check_val("rst_gyro_out", GyroOut, 0);
        check_val("rst_data_ready", DataReady, 0);
        check_val("rst_busy", Busy, 0);
        check_val("rst_drop", DropCount, 0);
        Reset = 1'b0;

        // Impulse response
        run_sample(511, 511, 511);
        check_val("impulse_first", out_ch(0), -9);
        run_sample(0, 0, 0);
        check_val("impulse_second", out_ch(1), 57);
        for (int i = 0; i < 9; i++) run_sample(0, 0, 0);
        check_val("impulse_settled", out_ch(2), 0);

        // DC rejection
        for (int i = 0; i < 12; i++) run_sample(300, 300, 300);
        check_val("dc_rejected", out_ch(0), 0);

        // Alternating full-scale-ish input drives the result past the output range
        for (int i = 0; i < 12; i++) begin
            sv = (i % 2 == 0) ? 256 : -256;
            run_sample(sv, sv, sv);
        end
`ifdef GYRO_FIR_SAT_EN
        check_val("alt_saturated", out_ch(0), 511);
`else
        check_val("alt_wrapped", out_ch(0), -1);
`endif

        // Random data with random (sometimes out-of-range) same-cycle coefficient writes
        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(0, 1023)) - 512;
            b = int'($urandom_range(0, 1023)) - 512;
            c = int'($urandom_range(0, 1023)) - 512;
            run_probe(a, b, c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 65535)), -1, 1'b0, 1'b0, -1);
        end

        // Sample offered while busy is dropped and never enters the delay line
        do_reset();
        run_probe(200, -100, 50, 1'b0, 0, 0, 5, 1'b1, 1'b0, -1);
        run_sample(0, 0, 0);

        // Coefficient load; a write while busy must be ignored
        do_reset();
        coef_write(0, 16'h7fff);
        for (int k = 1; k < TAPS; k++) coef_write(k, 0);
        run_probe(100, 100, 100, 1'b0, 0, 0, 5, 1'b0, 1'b1, -1);
        check_val("coef_load_out", out_ch(0), 100);
        run_sample(100, 100, 100);
        check_val("coef_busy_write_ignored", out_ch(1), 100);

        // Reset in the middle of the MAC phase aborts and restores defaults
        run_probe(50, -50, 7, 1'b0, 0, 0, 3, 1'b1, 1'b0, 15);
        run_sample(511, 511, 511);
        check_val("defaults_after_abort", out_ch(0), -9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
